// File: rtl/mvau_defn_pkg.sv
// mvau_defn: helpers and types shared across the MVAU blocks.
// sf_cnt_t is sized for the largest synapse fold the MVAU supports.
package mvau_defn;
    localparam int unsigned SF_MAX = 1024;
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    typedef logic [clog2_min1(SF_MAX)-1:0] sf_cnt_t;
endpackage

// File: rtl/mvu_pe_acc.sv
// mvu_pe_acc: per-PE fold accumulator behind the SIMD adder tree.
// Sums SF adder-tree beats into one result held on a registered valid/ready output.
module mvu_pe_acc
    import mvau_defn::*;
#(
    parameter int unsigned TI     = 16,
    parameter int unsigned TO     = 24,
    parameter int unsigned SF     = 4,
    parameter bit          SIGNED = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_v,
    output logic          in_rdy,
    input  logic [TI-1:0] in_add,
    output logic          out_v,
    input  logic          out_rdy,
    output logic [TO-1:0] out_acc
);
    logic [TO-1:0] acc_q, acc_d, out_acc_q, out_acc_d, sum, ext_s, ext_u, ext_add;
    sf_cnt_t sf_cnt_q, sf_cnt_d;
    logic out_v_q, out_v_d, in_fire, last;

    always_comb begin
        ext_s = TO'($signed(in_add));
        ext_u = TO'(in_add);
        ext_add = SIGNED ? ext_s : ext_u;
        in_rdy = ~rst & (~out_v_q | out_rdy);
        in_fire = in_v & in_rdy;
        last = sf_cnt_q == sf_cnt_t'(SF - 1);
        sum = (sf_cnt_q == '0) ? ext_add : acc_q + ext_add;
        acc_d = in_fire ? sum : acc_q;
        sf_cnt_d = in_fire ? (last ? '0 : sf_cnt_q + 1'b1) : sf_cnt_q;
        out_acc_d = (in_fire & last) ? sum : out_acc_q;
        // a final beat landing on a drain replaces the result without a bubble
        out_v_d = (in_fire & last) | (out_v_q & ~out_rdy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sf_cnt_q <= '0;
            out_v_q <= 1'b0;
            out_acc_q <= '0;
        end else begin
            acc_q <= acc_d;
            sf_cnt_q <= sf_cnt_d;
            out_v_q <= out_v_d;
            out_acc_q <= out_acc_d;
        end
    end

    assign out_v = out_v_q;
    assign out_acc = out_acc_q;
endmodule

// File: tb/tb_mvu_pe_acc.sv
// tb_mvu_pe_acc: directed vector table plus hand sequences and a random scoreboard run.
// Four instances share the stimulus: unsigned, signed, narrow-wrap and SF=1 variants.
module tb_mvu_pe_acc;
    typedef struct {
        logic r, v;
        logic [7:0] a;
        logic o, e_rdy, e_v;
        logic [11:0] e_acc;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, in_v = 1'b0, out_rdy = 1'b1;
    logic [7:0] in_add = '0;
    logic in_rdy0, in_rdy1, in_rdy2, in_rdy3, out_v0, out_v1, out_v2, out_v3;
    logic [11:0] acc0, acc1, acc3;
    logic [7:0] acc2;
    int nvec = 0, nerr = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mvu_pe_acc #(.TI(8), .TO(12), .SF(4), .SIGNED(1'b0)) u0 (.clk(clk), .rst(rst), .in_v(in_v),
        .in_rdy(in_rdy0), .in_add(in_add), .out_v(out_v0), .out_rdy(out_rdy), .out_acc(acc0));
    mvu_pe_acc #(.TI(8), .TO(12), .SF(4), .SIGNED(1'b1)) u1 (.clk(clk), .rst(rst), .in_v(in_v),
        .in_rdy(in_rdy1), .in_add(in_add), .out_v(out_v1), .out_rdy(out_rdy), .out_acc(acc1));
    mvu_pe_acc #(.TI(8), .TO(8), .SF(4), .SIGNED(1'b0)) u2 (.clk(clk), .rst(rst), .in_v(in_v),
        .in_rdy(in_rdy2), .in_add(in_add), .out_v(out_v2), .out_rdy(out_rdy), .out_acc(acc2));
    mvu_pe_acc #(.TI(8), .TO(12), .SF(1), .SIGNED(1'b0)) u3 (.clk(clk), .rst(rst), .in_v(in_v),
        .in_rdy(in_rdy3), .in_add(in_add), .out_v(out_v3), .out_rdy(out_rdy), .out_acc(acc3));

    function automatic void chk(string n, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", n, got, exp);
        end
    endfunction

    task automatic tv(logic r, logic v, logic [7:0] a, logic o, logic e_rdy, logic e_v, logic [11:0] e_acc);
        tbl.push_back('{r, v, a, o, e_rdy, e_v, e_acc});
    endtask

    // inputs change on the falling edge; all checks run 1 unit later
    task automatic drive(logic r, logic v, logic [7:0] a, logic o);
        @(negedge clk);
        rst = r;
        in_v = v;
        in_add = a;
        out_rdy = o;
        #1;
    endtask

    initial begin
        int popped;
        int nb;
        logic [11:0] beats [4];
        logic [11:0] q_exp [$];
        logic pv, pr;
        logic [11:0] pacc;
        // reset state, then 10+20+30+40
        tv(1, 0, 0, 1, 0, 0, 0);
        tv(0, 1, 10, 1, 1, 0, 0); tv(0, 1, 20, 1, 1, 0, 0); tv(0, 1, 30, 1, 1, 0, 0); tv(0, 1, 40, 1, 1, 0, 0);
        tv(0, 0, 0, 1, 1, 1, 100); tv(0, 0, 0, 1, 1, 0, 100);
        // back-pressure: result held for 5 cycles while in_v stays high
        tv(0, 1, 10, 1, 1, 0, 100); tv(0, 1, 20, 1, 1, 0, 100); tv(0, 1, 30, 1, 1, 0, 100); tv(0, 1, 40, 1, 1, 0, 100);
        for (int i = 0; i < 5; i++) tv(0, 1, 5, 0, 0, 1, 100);
        tv(0, 1, 5, 1, 1, 1, 100); tv(0, 1, 6, 1, 1, 0, 100); tv(0, 1, 7, 1, 1, 0, 100); tv(0, 1, 8, 1, 1, 0, 100);
        tv(0, 0, 0, 0, 0, 1, 26); tv(0, 0, 0, 1, 1, 1, 26); tv(0, 0, 0, 1, 1, 0, 26);
        // reset mid-accumulation drops the partial sum
        tv(0, 1, 50, 1, 1, 0, 26); tv(0, 1, 60, 1, 1, 0, 26); tv(1, 1, 70, 1, 0, 0, 26);
        tv(0, 1, 1, 1, 1, 0, 0); tv(0, 1, 1, 1, 1, 0, 0); tv(0, 1, 1, 1, 1, 0, 0); tv(0, 1, 1, 1, 1, 0, 0);
        tv(0, 0, 0, 1, 1, 1, 4); tv(0, 0, 0, 1, 1, 0, 4);
        // result followed immediately by the next group, first beat rides the drain
        tv(0, 1, 1, 1, 1, 0, 4); tv(0, 1, 2, 1, 1, 0, 4); tv(0, 1, 3, 1, 1, 0, 4); tv(0, 1, 4, 1, 1, 0, 4);
        tv(0, 1, 100, 1, 1, 1, 10); tv(0, 1, 100, 1, 1, 0, 10); tv(0, 1, 100, 1, 1, 0, 10); tv(0, 1, 100, 1, 1, 0, 10);
        tv(0, 0, 0, 1, 1, 1, 400); tv(0, 0, 0, 1, 1, 0, 400);

        drive(1, 0, 0, 1);
        drive(1, 0, 0, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].o);
            chk($sformatf("v%0d.in_rdy", i), in_rdy0, tbl[i].e_rdy);
            chk($sformatf("v%0d.out_v", i), out_v0, tbl[i].e_v);
            chk($sformatf("v%0d.out_acc", i), acc0, tbl[i].e_acc);
        end

        // sign handling and narrow wrap on the same beats
        drive(1, 0, 0, 1);
        drive(0, 1, 8'hFF, 1); drive(0, 1, 8'hFF, 1); drive(0, 1, 8'h02, 1); drive(0, 1, 8'h01, 1);
        drive(0, 0, 0, 1);
        chk("t2.unsigned_v", out_v0, 1); chk("t2.unsigned", acc0, 12'h201);
        chk("t2.signed_v", out_v1, 1); chk("t2.signed", acc1, 1);
        chk("t2.narrow", acc2, 1); chk("t2.sf1", acc3, 1);
        drive(1, 0, 0, 1);
        drive(0, 1, 200, 1); drive(0, 1, 100, 1); drive(0, 1, 0, 1); drive(0, 1, 0, 1);
        drive(0, 0, 0, 1);
        chk("t4.wrap_v", out_v2, 1); chk("t4.wrap", acc2, 44);
        chk("t4.wide", acc0, 300); chk("t4.signed", acc1, 44);

        // SF=1: consecutive results with no bubble
        drive(1, 0, 0, 1);
        drive(0, 1, 5, 1);
        chk("sf1.idle", out_v3, 0);
        drive(0, 1, 6, 1);
        chk("sf1.v0", out_v3, 1); chk("sf1.d0", acc3, 5);
        drive(0, 1, 7, 1);
        chk("sf1.v1", out_v3, 1); chk("sf1.d1", acc3, 6);
        drive(0, 0, 0, 1);
        chk("sf1.v2", out_v3, 1); chk("sf1.d2", acc3, 7);
        drive(0, 1, 9, 0);
        chk("sf1.drained", out_v3, 0); chk("sf1.rdy_empty", in_rdy3, 1);
        drive(0, 1, 9, 0);
        chk("sf1.stall", in_rdy3, 0); chk("sf1.hold", acc3, 9);

        // random handshakes against a transaction scoreboard on u0
        drive(1, 0, 0, 1);
        popped = 0;
        nb = 0;
        pv = 0;
        pr = 1;
        pacc = 0;
        for (int c = 0; c < 20000 && popped < 1000; c++) begin
            drive(0, $urandom_range(0, 9) < 7, 8'($urandom_range(0, 255)), $urandom_range(0, 9) < 7);
            if (pv && !pr) begin
                chk("rnd.hold_v", out_v0, 1);
                chk("rnd.hold_acc", acc0, pacc);
            end
            if (in_v && in_rdy0) begin
                beats[nb] = 12'(in_add);
                nb++;
                if (nb == 4) begin
                    q_exp.push_back(beats[0] + beats[1] + beats[2] + beats[3]);
                    nb = 0;
                end
            end
            if (out_v0 && out_rdy) begin
                if (q_exp.size() == 0) chk("rnd.spurious", 1, 0);
                else chk($sformatf("rnd.res%0d", popped), acc0, q_exp.pop_front());
                popped++;
            end
            pv = out_v0;
            pr = out_rdy;
            pacc = acc0;
        end
        chk("rnd.count", popped, 1000);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
